// File: rtl/match_event_logger_pkg.sv
// Shared constants and helpers for the match event logger.
package match_pkg;

    localparam int TS_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int CNT_WIDTH_DEF = 8;

    // Level counter needs one bit more than the pointers so it can hold DEPTH.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/match_event_logger_event_fifo.sv
// First-word-fall-through synchronous FIFO. push/pop arrive pre-qualified by
// the caller; clear empties the FIFO and overrides both.
module event_fifo
    import match_pkg::*;
#(
    parameter int WIDTH = TS_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic [WIDTH-1:0]              head
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointers wrap naturally at DEPTH (power of two); level decides full/empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/match_event_logger.sv
// Timestamps each sampled match pulse and queues the stamps for a
// valid/ready consumer. Also tracks a saturating match count and a sticky
// overflow flag for matches dropped on a full FIFO.
module match_event_logger
    import match_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          match_in,
    input  logic                          clear,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [TS_WIDTH-1:0]           ev_ts,
    output logic [CNT_WIDTH-1:0]          match_count,
    output logic                          overflow,
    output logic [level_width(DEPTH)-1:0] fifo_level
);

    logic [TS_WIDTH-1:0] ts;
    logic                fifo_full;
    logic                fifo_empty;
    logic                do_pop;
    logic                do_push;
    logic                drop;

    // A full FIFO still accepts a match when the head leaves at the same edge.
    assign do_pop   = ev_ready && !fifo_empty;
    assign do_push  = match_in && (!fifo_full || do_pop);
    assign drop     = match_in && fifo_full && !do_pop;
    assign ev_valid = !fifo_empty;

    // Free-running timestamp; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      ts <= '0;
        else if (clear) ts <= '0;
        else            ts <= ts + TS_WIDTH'(1);
    end

    // Match count includes dropped matches and sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             match_count <= '0;
        else if (clear)                        match_count <= '0;
        else if (match_in && match_count != '1) match_count <= match_count + CNT_WIDTH'(1);
    end

    // Overflow stays set until reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      overflow <= 1'b0;
        else if (clear) overflow <= 1'b0;
        else if (drop)  overflow <= 1'b1;
    end

    event_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (do_push),
        .pop   (do_pop),
        .din   (ts),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (ev_ts)
    );

endmodule

// File: tb/tb_match_event_logger.sv
// Self-checking bench for match_event_logger: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_match_event_logger;
    import match_pkg::*;

    localparam int TSW = 4;
    localparam int DEP = 4;
    localparam int CW  = 8;
    localparam int LW  = level_width(DEP);

    logic           clk = 1'b0;
    logic           reset;
    logic           match_in;
    logic           clear;
    logic           ev_ready;
    logic           ev_valid;
    logic [TSW-1:0] ev_ts;
    logic [CW-1:0]  match_count;
    logic           overflow;
    logic [LW-1:0]  fifo_level;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int ts_m;
    int cnt_m;
    int ovf_m;
    int q[$];

    match_event_logger #(
        .TS_WIDTH  (TSW),
        .DEPTH     (DEP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .match_in    (match_in),
        .clear       (clear),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ts       (ev_ts),
        .match_count (match_count),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ts_m  = 0;
        cnt_m = 0;
        ovf_m = 0;
        q     = {};
    endtask

    // One clock edge of the reference behaviour, using pre-edge state.
    task automatic model_edge(input bit m, input bit r, input bit c);
        bit popped;
        if (c) begin
            model_reset();
            return;
        end
        popped = (q.size() != 0) && r;
        if (popped) void'(q.pop_front());
        if (m) begin
            if (cnt_m < (1 << CW) - 1) cnt_m++;
            if (q.size() == DEP) ovf_m = 1;
            else q.push_back(ts_m);
        end
        ts_m = (ts_m + 1) % (1 << TSW);
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":ev_valid"}, 32'(ev_valid), 32'(q.size() != 0));
        chk({ctx, ":ev_ts"}, 32'(ev_ts), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({ctx, ":fifo_level"}, 32'(fifo_level), 32'(q.size()));
        chk({ctx, ":match_count"}, 32'(match_count), 32'(cnt_m));
        chk({ctx, ":overflow"}, 32'(overflow), 32'(ovf_m));
    endtask

    // Drive inputs mid-cycle, take one edge, then compare 1 time unit later.
    task automatic step(input bit m, input bit r, input bit c, input string ctx);
        match_in = m;
        ev_ready = r;
        clear    = c;
        @(posedge clk);
        model_edge(m, r, c);
        #1;
        check_all(ctx);
    endtask

    initial begin
        bit m, r, c;

        reset    = 1'b1;
        match_in = 1'b0;
        clear    = 1'b0;
        ev_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // Matches on 1st and 4th edges -> entries 0 and 3
        step(1, 0, 0, "t1");
        step(0, 0, 0, "t1");
        step(0, 0, 0, "t1");
        step(1, 0, 0, "t1");
        chk("t1_level_const", 32'(fifo_level), 32'd2);
        chk("t1_head_const", 32'(ev_ts), 32'd0);
        chk("t1_count_const", 32'(match_count), 32'd2);

        // Drain both entries
        step(0, 1, 0, "t2");
        chk("t2_head_const", 32'(ev_ts), 32'd3);
        step(0, 1, 0, "t2");
        step(0, 1, 0, "t2");
        chk("t2_valid_const", 32'(ev_valid), 32'd0);
        chk("t2_count_const", 32'(match_count), 32'd2);

        // Clear together with a match: clear wins, ts restarts
        step(1, 0, 1, "clear");

        // 6 matches into a 4-deep FIFO -> 0..3 kept, overflow set
        for (int i = 0; i < 6; i++) step(1, 0, 0, "fill");
        chk("fill_overflow_const", 32'(overflow), 32'd1);
        chk("fill_count_const", 32'(match_count), 32'd6);
        for (int i = 0; i < 4; i++) step(0, 0, 0, "idle");

        // Full + match + pop at ts=10
        step(1, 1, 0, "fullpop");
        chk("fullpop_tail", 32'(q[DEP-1]), 32'd10);
        chk("fullpop_level_const", 32'(fifo_level), 32'd4);
        chk("fullpop_head_const", 32'(ev_ts), 32'd1);

        // A mid-cycle glitch on match_in is not sampled
        match_in = 1'b1;
        #2;
        match_in = 1'b0;
        step(0, 0, 0, "glitch");

        // Counter saturation
        step(0, 0, 1, "clear2");
        for (int i = 0; i < 300; i++) step(1, 1, 0, "sat");
        chk("sat_count_const", 32'(match_count), 32'd255);
        chk("sat_overflow_const", 32'(overflow), 32'd0);

        // Timestamp wrap: match at ts=15, then at ts=0
        step(0, 0, 1, "clear3");
        for (int i = 0; i < 15; i++) step(0, 0, 0, "wrap_idle");
        step(1, 0, 0, "wrap");
        step(1, 0, 0, "wrap");
        chk("wrap_head_const", 32'(ev_ts), 32'd15);
        step(0, 1, 0, "wrap_pop");
        chk("wrap_next_const", 32'(ev_ts), 32'd0);

        // Async reset mid-cycle with 3 entries queued
        step(0, 0, 1, "clear4");
        for (int i = 0; i < 3; i++) step(1, 0, 0, "pre_areset");
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("areset");
        #2;
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            m = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 2) != 0 ? $urandom_range(0, 1) : 0);
            c = ($urandom_range(0, 40) == 0);
            step(m, r, c, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
Downstream consumer of the serial sequence detector's one-cycle match pulse. Stamps each match with a free-running cycle timestamp and buffers the stamps in a small FIFO. The FIFO drains over a valid/ready interface to the host or status logic. Also keeps a saturating match count and a sticky overflow flag.

Parameters:
TS_WIDTH, 16, width of free-running timestamp counter and of each logged entry
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_WIDTH, 8, width of saturating match counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
match_in  input  1  detector match pulse; sampled on rising clk edge
clear  input  1  synchronous clear of all state (same effect as reset)
ev_valid  output  1  FIFO head holds a valid entry
ev_ready  input  1  consumer accepts head this cycle
ev_ts  output  TS_WIDTH  timestamp at FIFO head; 0 when empty
match_count  output  CNT_WIDTH  matches seen since reset/clear, saturating
overflow  output  1  sticky: a match was dropped because the FIFO was full
fifo_level  output  clog2(DEPTH)+1  entries currently stored

Behaviour:
- Reset (async, active-high): ts counter=0, FIFO empty, ev_valid=0, ev_ts=0, match_count=0, overflow=0, fifo_level=0.
- clear=1 at an edge: same result as reset at that edge. Overrides match_in and pop in that cycle, and the ts counter is also zeroed.
- Timestamp counter ts: increments by 1 every edge and wraps from 2^TS_WIDTH-1 to 0. No saturation.
- match_in is registered only by sampling. It may come from a Mealy output and glitch mid-cycle; only its value at the edge counts. A high level on consecutive edges counts as separate matches.
- Push: at an edge with match_in=1, the pre-increment value of ts is written. Example: edge where ts==5 logs 5.
- Pop: at an edge with ev_valid=1 and ev_ready=1, the head is removed. ev_ready is ignored while ev_valid=0.
- FIFO is first-word-fall-through:
  - ev_valid = (level != 0).
  - ev_ts = head entry, combinational from FIFO state and not from inputs.
  - Push-to-valid latency is 1 edge: match at edge N gives ev_valid=1 right after edge N.
- Full, match, no pop: entry dropped, overflow set to 1 and held until reset/clear, level unchanged.
- Full, match, pop at the same edge: both happen, no drop, level stays DEPTH, new entry goes to tail.
- Empty, match, ev_ready=1: push only, because no pop is possible while empty.
- match_count: +1 per sampled match, including dropped ones. Saturates at 2^CNT_WIDTH-1 with no wrap.
- Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided by the level counter.
- No output depends combinationally on match_in, ev_ready or clear.

Decomposition:
- Shared package match_pkg: default constants TS_WIDTH_DEF=16, DEPTH_DEF=4, CNT_WIDTH_DEF=8, and a level-width function (clog2(DEPTH)+1).
- One sub-module, event_fifo: parameterised FWFT sync FIFO with push, pop, full, empty, level and head outputs.
- The top holds the ts counter, match counter, overflow flag and push/pop/drop decisions.

Test Plan:
- Reset release, then match_in=1 on the 1st and 4th edges, ev_ready=0 -> entries 0 and 3; ev_valid=1; fifo_level=2; match_count=2.
- Then ev_ready=1 for 2 cycles -> ev_ts shows 0 then 3; ev_valid=0 and ev_ts=0 afterwards; match_count stays 2.
- DEPTH=4, ev_ready=0, 6 consecutive matches from ts=0 -> FIFO holds 0,1,2,3; overflow=1; match_count=6; fifo_level=4.
- FIFO full, match_in=1 and ev_ready=1 at the same edge with ts=10 -> head popped; 10 appended; level stays 4; overflow unchanged.
- CNT_WIDTH=8: 300 matches with ev_ready=1 -> match_count=255; overflow=0.
- Async reset asserted mid-cycle with 3 entries queued -> all outputs 0 immediately, without waiting for a clk edge.
- clear=1 together with match_in=1 -> next cycle level=0, match_count=0, overflow=0, and ts restarts at 0.
- Wrap check with TS_WIDTH=4: match at ts=15, then match at the next edge -> logged 15, then 0.
